vga_timing_gen: RTL

- Parametrised successor to the fixed 640x480 pulse generator and clock divider pair.
- Produces horizontal/vertical sync, active-video flag, pixel coordinates, line/frame strobes and a frame counter from one system clock, using an internal pixel clock-enable instead of a derived clock.
- Sits between the system clock and the pixel renderers (number blocks, colour gating); all renderers consume x/y/active on pix_ce cycles.

---
 rtl/vga_timing_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : Parametrised video timing generator. Produces sync, active-video,
//            pixel coordinates, line/frame strobes and a frame counter from a
//            single system clock using an internal pixel clock-enable.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int PIX_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int FCW      = 8,
  parameter int XW       = 11
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  output logic           pix_ce,
  output logic           hs,
  output logic           vs,
  output logic           active,
  output logic [XW-1:0]  x,
  output logic [XW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count
);

  localparam int C_H_TOT   = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int C_V_TOT   = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int C_HW      = (C_H_TOT > 1) ? $clog2(C_H_TOT) : 1;
  localparam int C_VW      = (C_V_TOT > 1) ? $clog2(C_V_TOT) : 1;
  localparam int C_DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int C_MAX_ACT = (H_ACTIVE > V_ACTIVE) ? H_ACTIVE : V_ACTIVE;
  localparam int C_H_ACT_B = H_SYNC + H_BP;
  localparam int C_H_ACT_E = H_SYNC + H_BP + H_ACTIVE;
  localparam int C_V_ACT_B = V_SYNC + V_BP;
  localparam int C_V_ACT_E = V_SYNC + V_BP + V_ACTIVE;

  localparam logic [C_DW-1:0] C_DIV_LAST = C_DW'(PIX_DIV - 1);
  localparam logic [C_HW-1:0] C_H_LAST   = C_HW'(C_H_TOT - 1);
  localparam logic [C_VW-1:0] C_V_LAST   = C_VW'(C_V_TOT - 1);
  localparam logic            C_HS_ON    = (HS_POL != 0);
  localparam logic            C_VS_ON    = (VS_POL != 0);

  // Coordinates must be wide enough for the larger visible dimension.
  if (XW < $clog2(C_MAX_ACT)) begin : g_xw_check
    $fatal(1, "vga_timing_gen: XW too narrow for the active area");
  end

  logic [C_DW-1:0] div_q, div_d;
  logic [C_HW-1:0] h_q, h_d;
  logic [C_VW-1:0] v_q, v_d;
  logic            pix_ce_q, pix_ce_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            active_q, active_d;
  logic [XW-1:0]   x_q, x_d;
  logic [XW-1:0]   y_q, y_d;
  logic            line_q, line_d;
  logic            frame_q, frame_d;
  logic [FCW-1:0]  fc_q, fc_d;

  logic            w_wrap;
  logic            w_h_act;
  logic            w_v_act;
  int              w_h_int;
  int              w_v_int;

  // Divider and position counters advance; outputs are decoded from the
  // next counter values so they line up with the counters themselves.
  always_comb begin
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    w_wrap   = en && (div_q == C_DIV_LAST);

    if (en) begin
      div_d = w_wrap ? '0 : div_q + C_DW'(1);
    end
    if (w_wrap) begin
      if (h_q == C_H_LAST) begin
        h_d = '0;
        v_d = (v_q == C_V_LAST) ? '0 : v_q + C_VW'(1);
      end else begin
        h_d = h_q + C_HW'(1);
      end
    end

    w_h_int  = 32'(h_d);
    w_v_int  = 32'(v_d);
    w_h_act  = (w_h_int >= C_H_ACT_B) && (w_h_int < C_H_ACT_E);
    w_v_act  = (w_v_int >= C_V_ACT_B) && (w_v_int < C_V_ACT_E);

    pix_ce_d = w_wrap;
    hs_d     = (w_h_int < H_SYNC) ? C_HS_ON : ~C_HS_ON;
    vs_d     = (w_v_int < V_SYNC) ? C_VS_ON : ~C_VS_ON;
    active_d = w_h_act && w_v_act;
    x_d      = w_h_act ? XW'(w_h_int - C_H_ACT_B) : '0;
    y_d      = w_v_act ? XW'(w_v_int - C_V_ACT_B) : '0;
    line_d   = w_wrap && (h_q == C_H_LAST);
    frame_d  = line_d && (v_q == C_V_LAST);
    fc_d     = frame_d ? fc_q + FCW'(1) : fc_q;
  end

  // State and output registers; reset lands on position (0,0) in sync.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      pix_ce_q <= 1'b0;
      hs_q     <= C_HS_ON;
      vs_q     <= C_VS_ON;
      active_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fc_q     <= '0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      pix_ce_q <= pix_ce_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      fc_q     <= fc_d;
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign active      = active_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_count = fc_q;

endmodule
`default_nettype wire
